// File: rtl/pc.sv
// rtl/pc.sv - program counter with sequential, branch, jump-register and jump next-PC selection
//
// Purpose:
//   Holds the current instruction address and computes the next one. A single
//   32-bit register (pc_q) is updated on the rising clock when PCWre is high.
//   While reset is high the visible PC follows init directly, with no clock needed.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-high reset; PC0 follows init while high
//   PCWre   in   1   1 = load next-PC on the next rising clk, 0 = hold
//   Extend  in  32   sign-extended branch offset, in words
//   rs      in  32   jump-register target, loaded verbatim
//   init    in  32   PC value presented and captured while reset is high
//   OP      in  32   current instruction; OP[25:0] is the J-type target
//   PCSrc   in   2   00 seq, 01 branch, 10 jump register, 11 jump
//   PC0     out 32   current PC
//   PC4     out 32   PC0 + 4, combinational

module pc (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWre,
  input  logic [31:0] Extend,
  input  logic [31:0] rs,
  input  logic [31:0] init,
  input  logic [31:0] OP,
  input  logic [1:0]  PCSrc,
  output logic [31:0] PC0,
  output logic [31:0] PC4
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JR     = 2'b10;
  localparam logic [1:0] SRC_JUMP   = 2'b11;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  // An async reset only captures init at the reset edge; forwarding init
  // straight to the output keeps PC0 tracking init for the whole reset period.
  // pc_q is also reloaded with init on every clock edge seen during reset.
  assign PC0 = reset ? init : pc_q;
  assign PC4 = PC0 + 32'd4;

  // Offset is in words; the shift discards the top two bits, and the add wraps.
  assign branch_tgt = PC4 + {Extend[29:0], 2'b00};
  assign jump_tgt   = {PC4[31:28], OP[25:0], 2'b00};

  always_comb begin
    pc_d = PC4;
    unique case (PCSrc)
      SRC_SEQ:    pc_d = PC4;
      SRC_BRANCH: pc_d = branch_tgt;
      SRC_JR:     pc_d = rs;
      SRC_JUMP:   pc_d = jump_tgt;
      default:    pc_d = PC4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= init;
    end else if (PCWre) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - directed self-checking bench for pc
`timescale 1ns/1ps

module tb_pc;

  logic        clk;
  logic        reset;
  logic        PCWre;
  logic [31:0] Extend;
  logic [31:0] rs;
  logic [31:0] init;
  logic [31:0] OP;
  logic [1:0]  PCSrc;
  logic [31:0] PC0;
  logic [31:0] PC4;

  int n_chk;
  int n_pass;

  pc dut (
    .clk    (clk),
    .reset  (reset),
    .PCWre  (PCWre),
    .Extend (Extend),
    .rs     (rs),
    .init   (init),
    .OP     (OP),
    .PCSrc  (PCSrc),
    .PC0    (PC0),
    .PC4    (PC4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    PCWre  = 1'b0;
    Extend = 32'h0;
    rs     = 32'h0;
    init   = 32'h28;
    OP     = 32'h0;
    PCSrc  = 2'b00;

    // Reset load before any clock edge, and init tracking while in reset
    #1;
    check("rst_pc0", PC0, 32'h28);
    check("rst_pc4", PC4, 32'h2C);
    init = 32'h44;
    #1;
    check("rst_track_pc0", PC0, 32'h44);
    check("rst_track_pc4", PC4, 32'h48);
    init = 32'h28;
    @(negedge clk);
    check("rst_hold_clk", PC0, 32'h28);

    // Release; an edge with PCWre=0 must not move PC, even with PCSrc active
    reset = 1'b0;
    PCSrc = 2'b11;
    OP    = 32'h0000_1234;
    step();
    check("post_rst_hold", PC0, 32'h28);

    // Sequential
    PCWre = 1'b1;
    PCSrc = 2'b00;
    step();
    check("seq_pc0", PC0, 32'h2C);
    check("seq_pc4", PC4, 32'h30);

    // Jump: {0x0, 0x64<<2}
    PCSrc = 2'b11;
    OP    = 32'h0000_0064;
    step();
    check("jump_pc0", PC0, 32'h190);

    // Branch backwards: 0x194 - 8
    PCSrc  = 2'b01;
    Extend = 32'hFFFF_FFFE;
    step();
    check("branch_neg", PC0, 32'h18C);

    // Back to 0x190, then branch forward: 0x194 + 12
    PCSrc = 2'b11;
    step();
    check("jump_again", PC0, 32'h190);
    PCSrc  = 2'b01;
    Extend = 32'h0000_0003;
    step();
    check("branch_pos", PC0, 32'h1A0);

    // Jump register, unaligned value loads verbatim
    PCSrc = 2'b10;
    rs    = 32'h0000_1003;
    step();
    check("jr_unaligned", PC0, 32'h1003);
    rs = 32'h0000_1000;
    step();
    check("jr_pc0", PC0, 32'h1000);

    // Hold across three edges with every input toggling
    PCWre = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PCSrc  = 2'(i);
      Extend = 32'h1111_1111 * (i + 1);
      rs     = 32'hA5A5_0000 + i;
      OP     = ~OP;
      init   = 32'hDEAD_0000 + i;
      step();
      check($sformatf("hold_%0d", i), PC0, 32'h1000);
    end

    // Async reset mid-cycle: takes effect with no clock edge
    init = 32'h28;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pc0", PC0, 32'h28);
    check("async_rst_pc4", PC4, 32'h2C);
    @(negedge clk);
    reset = 1'b0;
    PCWre = 1'b1;
    PCSrc = 2'b00;
    step();
    check("after_async_seq", PC0, 32'h2C);

    // Jump keeps PC4[31:28]; then wrap through the top of the address space
    PCSrc = 2'b10;
    rs    = 32'hF000_0000;
    step();
    check("jr_high", PC0, 32'hF000_0000);
    PCSrc = 2'b11;
    OP    = 32'h03FF_FFFF;
    step();
    check("jump_high", PC0, 32'hFFFF_FFFC);
    check("pc4_wrap", PC4, 32'h0000_0000);
    PCSrc = 2'b00;
    step();
    check("seq_wrap", PC0, 32'h0000_0000);

    // Branch wrap-around: 0x4 + (-4 words) wraps to 0xFFFFFFF4
    PCSrc  = 2'b01;
    Extend = 32'hFFFF_FFFC;
    step();
    check("branch_wrap", PC0, 32'hFFFF_FFF4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
